// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-Lite slave to APB3 master bridge; decode misses, P_SLVERR and hung slaves become AHB ERROR.
// Latency: read 2 / write 3 data-phase cycles with a zero-wait slave, plus APB wait states.
// Backpressure: H_READY_OUT held low until the APB access completes, errors or times out.
module ahb_apb_bridge_mslv #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_SLV     = 4,
    parameter int SLV_SEL_LSB = 12,
    parameter int TIMEOUT     = 256
) (
    input  logic                          H_CLK,
    input  logic                          H_RESET_n,
    input  logic                          H_SEL,
    input  logic                          H_READY_IN,
    input  logic [1:0]                    H_TRANS,
    input  logic                          H_WRITE,
    input  logic [2:0]                    H_SIZE,
    input  logic [ADDR_WIDTH-1:0]         H_ADDR,
    input  logic [DATA_WIDTH-1:0]         H_WDATA,
    output logic [DATA_WIDTH-1:0]         H_RDATA,
    output logic                          H_READY_OUT,
    output logic                          H_RESP,
    output logic [NUM_SLV-1:0]            P_SEL,
    output logic                          P_ENABLE,
    output logic                          P_WRITE,
    output logic [ADDR_WIDTH-1:0]         P_ADDR,
    output logic [DATA_WIDTH-1:0]         P_WDATA,
    output logic [DATA_WIDTH/8-1:0]       P_STRB,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] P_RDATA,
    input  logic [NUM_SLV-1:0]            P_READY,
    input  logic [NUM_SLV-1:0]            P_SLVERR
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int LOG_NB = $clog2(NB);
    localparam int OFF_W  = (LOG_NB < 1) ? 1 : LOG_NB;
    localparam int IDX_W  = (NUM_SLV < 2) ? 1 : $clog2(NUM_SLV);
    localparam int NPAD   = 1 << IDX_W;
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WWAIT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [NB-1:0]           strb_q;
    logic [NUM_SLV-1:0]      psel_q;
    logic                    penable_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [IDX_W-1:0]        dec_idx;
    logic                    dec_miss;
    logic                    accept;
    logic                    take;
    logic [NPAD-1:0]         rdy_ext;
    logic [NPAD-1:0]         err_ext;
    logic                    sel_rdy;
    logic                    sel_err;
    logic                    done_ok;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    timeout_hit;
    logic                    unused_sig;

    function automatic logic [NB-1:0] strb_f(input logic [2:0] size, input logic [OFF_W-1:0] low);
        logic [NB-1:0] s;
        int            lanes;
        int            off;
        s     = '0;
        lanes = 0;
        off   = 0;
        if (int'(size) >= LOG_NB) begin
            s = '1;
        end else begin
            lanes = 1 << size;
            off   = int'(low) & ~(lanes - 1);
            for (int i = 0; i < NB; i++) s[i] = (i >= off) && (i < off + lanes);
        end
        return s;
    endfunction

    function automatic logic [NUM_SLV-1:0] onehot_f(input logic [IDX_W-1:0] i);
        logic [NUM_SLV-1:0] r;
        for (int k = 0; k < NUM_SLV; k++) r[k] = (i == IDX_W'(k));
        return r;
    endfunction

    assign dec_idx     = H_ADDR[SLV_SEL_LSB +: IDX_W];
    assign dec_miss    = (int'(dec_idx) >= NUM_SLV);
    assign accept      = H_SEL & H_READY_IN & H_TRANS[1];
    assign rdy_ext     = NPAD'(P_READY);
    assign err_ext     = NPAD'(P_SLVERR);
    assign sel_rdy     = rdy_ext[idx_q];
    assign sel_err     = err_ext[idx_q];
    assign done_ok     = (state_q == S_ACCESS) & sel_rdy & ~sel_err;
    // A new transfer is only looked at when the bridge is about to signal ready.
    assign take        = accept & ((state_q == S_IDLE) | (state_q == S_ERR2) | done_ok);
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT > 0) && (cnt_inc == CNT_W'(TIMEOUT));
    assign unused_sig  = H_TRANS[0];

    always_comb begin
        H_READY_OUT = 1'b0;
        case (state_q)
            S_IDLE, S_ERR2: H_READY_OUT = 1'b1;
            S_ACCESS:       H_READY_OUT = done_ok;
            default:        H_READY_OUT = 1'b0;
        endcase
    end

    always_comb begin
        H_RDATA = '0;
        if (state_q == S_ACCESS && !write_q) begin
            for (int i = 0; i < NUM_SLV; i++) begin
                if (idx_q == IDX_W'(i)) H_RDATA = P_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign H_RESP   = (state_q == S_ERR1) | (state_q == S_ERR2);
    assign P_SEL    = psel_q;
    assign P_ENABLE = penable_q;
    assign P_WRITE  = write_q;
    assign P_ADDR   = addr_q;
    assign P_WDATA  = pwdata_q;
    assign P_STRB   = strb_q;

    always_ff @(posedge H_CLK or negedge H_RESET_n) begin
        if (!H_RESET_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            strb_q    <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwdata_q  <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_WWAIT: begin
                    pwdata_q <= H_WDATA;
                    psel_q   <= onehot_f(idx_q);
                    state_q  <= S_SETUP;
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (sel_rdy) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        state_q   <= sel_err ? S_ERR1 : S_IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (timeout_hit) begin
                            psel_q    <= '0;
                            penable_q <= 1'b0;
                            state_q   <= S_ERR1;
                        end
                    end
                end
                S_ERR1:  state_q <= S_ERR2;
                default: begin
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
            // Later assignments win: an accepted transfer overrides the return to IDLE.
            if (take) begin
                addr_q    <= H_ADDR;
                write_q   <= H_WRITE;
                idx_q     <= dec_idx;
                strb_q    <= H_WRITE ? strb_f(H_SIZE, H_ADDR[OFF_W-1:0]) : '0;
                penable_q <= 1'b0;
                if (dec_miss) begin
                    psel_q  <= '0;
                    state_q <= S_ERR1;
                end else if (H_WRITE) begin
                    psel_q  <= '0;
                    state_q <= S_WWAIT;
                end else begin
                    psel_q  <= onehot_f(dec_idx);
                    state_q <= S_SETUP;
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_apb_bridge_mslv.sv
// Randomized pipelined AHB master plus APB slave models, checked per transfer against a
// transaction-level model of latency, response, read data and APB signalling.
module tb_ahb_apb_bridge_mslv;
    localparam int NS   = 3;
    localparam int TO   = 4;
    localparam int N    = 160;
    localparam int NDIR = 9;

    logic          H_CLK, H_RESET_n, H_SEL, H_READY_IN, H_WRITE;
    logic [1:0]    H_TRANS;
    logic [2:0]    H_SIZE;
    logic [31:0]   H_ADDR, H_WDATA, H_RDATA;
    logic          H_READY_OUT, H_RESP;
    logic [NS-1:0] P_SEL, P_READY, P_SLVERR;
    logic          P_ENABLE, P_WRITE;
    logic [31:0]   P_ADDR, P_WDATA;
    logic [3:0]    P_STRB;
    logic [NS*32-1:0] P_RDATA;

    ahb_apb_bridge_mslv #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SLV(NS),
                          .SLV_SEL_LSB(12), .TIMEOUT(TO)) dut (
        .H_CLK(H_CLK), .H_RESET_n(H_RESET_n), .H_SEL(H_SEL), .H_READY_IN(H_READY_IN),
        .H_TRANS(H_TRANS), .H_WRITE(H_WRITE), .H_SIZE(H_SIZE), .H_ADDR(H_ADDR),
        .H_WDATA(H_WDATA), .H_RDATA(H_RDATA), .H_READY_OUT(H_READY_OUT), .H_RESP(H_RESP),
        .P_SEL(P_SEL), .P_ENABLE(P_ENABLE), .P_WRITE(P_WRITE), .P_ADDR(P_ADDR),
        .P_WDATA(P_WDATA), .P_STRB(P_STRB), .P_RDATA(P_RDATA), .P_READY(P_READY),
        .P_SLVERR(P_SLVERR));

    initial begin
        H_CLK = 1'b0;
        forever #5 H_CLK = ~H_CLK;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transfer list
    logic [31:0] ta[N], td[N], trd[N];
    logic [2:0]  tsz[N];
    bit          tw[N], terr[N];
    int          twait[N];

    function automatic int tidx(input int k);
        return int'(ta[k][13:12]);
    endfunction

    function automatic bit tmiss(input int k);
        return tidx(k) >= NS;
    endfunction

    function automatic bit exp_err(input int k);
        return tmiss(k) || twait[k] >= TO || terr[k];
    endfunction

    // Data-phase cycles: optional write-data wait, SETUP, stalled ACCESS cycles, then
    // either one completing ACCESS or the two-cycle error response.
    function automatic int exp_cyc(input int k);
        int wr;
        wr = tw[k] ? 1 : 0;
        if (tmiss(k)) return 2;
        if (twait[k] >= TO) return wr + 1 + TO + 2;
        if (terr[k]) return wr + twait[k] + 4;
        return wr + twait[k] + 2;
    endfunction

    function automatic logic [3:0] exp_strb(input int k);
        int lanes, off;
        if (!tw[k]) return 4'h0;
        if (tsz[k] >= 3'd2) return 4'hF;
        lanes = 1 << tsz[k];
        off   = int'(ta[k] % 4);
        off   = off - (off % lanes);
        return 4'(((1 << lanes) - 1) << off);
    endfunction

    task automatic set_tx(input int k, input bit w, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] d, input int wt, input bit e, input logic [31:0] rd);
        tw[k] = w; ta[k] = a; tsz[k] = s; td[k] = d; twait[k] = wt; terr[k] = e; trd[k] = rd;
    endtask

    int ap, dp, cyc, acc, gk, total;
    bit gap, prev_pen, prev_rdy, prev_resp, stop;
    logic [NS-1:0] prev_sel, exp_sel;
    int r, ix;

    initial begin
        H_RESET_n = 1'b0; H_SEL = 1'b0; H_READY_IN = 1'b1; H_TRANS = 2'b00; H_WRITE = 1'b0;
        H_SIZE = 3'd0; H_ADDR = '0; H_WDATA = '0; P_READY = '0; P_SLVERR = '0; P_RDATA = '0;

        set_tx(0, 0, 32'h0000_1004, 3'd2, 32'h0, 0, 0, 32'hA5A5_0001);
        set_tx(1, 1, 32'h0000_2003, 3'd0, 32'h1122_3344, 0, 0, 32'h0);
        set_tx(2, 0, 32'h0000_0000, 3'd2, 32'h0, 3, 1, 32'hDEAD_0000);
        set_tx(3, 0, 32'h0000_3000, 3'd2, 32'h0, 0, 0, 32'h0);
        set_tx(4, 0, 32'h0000_1008, 3'd2, 32'h0, 20, 0, 32'h0);
        set_tx(5, 1, 32'h0000_2000, 3'd2, 32'hCAFE_F00D, 0, 0, 32'h0);
        set_tx(6, 0, 32'h0000_0010, 3'd2, 32'h0, 0, 0, 32'h1111_0000);
        set_tx(7, 1, 32'h0000_1012, 3'd1, 32'h5566_7788, 0, 0, 32'h0);
        set_tx(8, 0, 32'h0000_0020, 3'd2, 32'h0, 0, 0, 32'h2222_0000);
        for (int k = NDIR; k < N; k++) begin
            r  = $urandom % 8;
            ix = (r == 7) ? 3 : r % 3;
            ta[k] = $urandom;
            ta[k][13:12] = 2'(ix);
            tw[k] = 1'($urandom % 2);
            tsz[k] = tw[k] ? 3'($urandom % 4) : 3'd2;
            td[k] = $urandom;
            trd[k] = $urandom;
            r = $urandom % 10;
            twait[k] = (r < 6) ? r % 3 : 3 + ($urandom % 4);
            terr[k] = ($urandom % 6) == 0;
        end

        // Reset values
        repeat (2) @(posedge H_CLK);
        #1;
        chk("rst_hready", H_READY_OUT, 1'b1);
        chk("rst_hresp", H_RESP, 1'b0);
        chk("rst_hrdata", H_RDATA, 32'h0);
        chk("rst_psel", P_SEL, 3'b000);
        chk("rst_penable", P_ENABLE, 1'b0);
        chk("rst_pwrite", P_WRITE, 1'b0);
        chk("rst_paddr", P_ADDR, 32'h0);
        chk("rst_pwdata", P_WDATA, 32'h0);
        chk("rst_pstrb", P_STRB, 4'h0);
        H_RESET_n = 1'b1;

        ap = 0; dp = -1; cyc = 0; acc = 0; gap = 0; gk = 0; total = 0; stop = 0;
        prev_pen = 0; prev_sel = '0; prev_rdy = 1; prev_resp = 0;
        while ((ap < N || dp >= 0) && !stop) begin
            @(posedge H_CLK);
            #1;
            total++;
            // AHB address phase (held until H_READY_OUT accepts it)
            if (ap < N && !gap) begin
                H_SEL = 1'b1; H_TRANS = 2'b10; H_WRITE = tw[ap]; H_SIZE = tsz[ap]; H_ADDR = ta[ap];
            end else begin
                H_SEL   = (gk != 0);
                H_TRANS = (gk == 0) ? 2'b10 : (gk == 1) ? 2'b00 : 2'b01;
                H_WRITE = 1'($urandom); H_SIZE = 3'($urandom); H_ADDR = $urandom;
            end
            H_WDATA = (dp >= 0 && tw[dp]) ? td[dp] : $urandom;
            // APB slaves: noise everywhere except the selected slave during ACCESS
            P_READY = NS'($urandom); P_SLVERR = NS'($urandom);
            for (int s = 0; s < NS; s++) P_RDATA[s*32 +: 32] = $urandom;
            if (dp >= 0) begin
                exp_sel = tmiss(dp) ? '0 : NS'(1 << tidx(dp));
                if (P_SEL != '0 || tmiss(dp)) chk("psel", P_SEL, exp_sel);
                if (P_ENABLE && !tmiss(dp)) begin
                    if (acc == 0) begin
                        chk("setup", {prev_pen, prev_sel}, {1'b0, exp_sel});
                        chk("paddr", P_ADDR, ta[dp]);
                        chk("pwrite", P_WRITE, tw[dp]);
                        chk("pstrb", P_STRB, exp_strb(dp));
                    end
                    if (tw[dp]) chk("pwdata", P_WDATA, td[dp]);
                    P_READY[tidx(dp)] = (acc == twait[dp]);
                    if (acc == twait[dp]) P_SLVERR[tidx(dp)] = terr[dp];
                    P_RDATA[tidx(dp)*32 +: 32] = trd[dp];
                    acc++;
                end else begin
                    acc = 0;
                end
            end else begin
                chk("apb_idle", {P_SEL, P_ENABLE}, '0);
                acc = 0;
            end
            prev_sel = P_SEL; prev_pen = P_ENABLE;
            #1;
            if (dp >= 0) begin
                cyc++;
                if (H_RESP) chk("err_psel", {P_SEL, P_ENABLE}, '0);
                if (H_READY_OUT) begin
                    chk("latency", cyc, exp_cyc(dp));
                    chk("hresp", H_RESP, exp_err(dp));
                    if (exp_err(dp)) chk("err_first", {prev_rdy, prev_resp}, 2'b01);
                    else if (!tw[dp]) chk("hrdata", H_RDATA, trd[dp]);
                end else if (cyc > 40) begin
                    chk("stall_bound", cyc, exp_cyc(dp));
                    stop = 1;
                end
            end else begin
                chk("ahb_idle", {H_READY_OUT, H_RESP}, 2'b10);
            end
            if (total > 20000) begin
                chk("watchdog", total, 0);
                stop = 1;
            end
            prev_rdy = H_READY_OUT; prev_resp = H_RESP;
            H_READY_IN = H_READY_OUT;
            if (H_READY_OUT) begin
                if (ap < N && !gap) begin
                    dp = ap;
                    ap++;
                end else begin
                    dp = -1;
                end
                cyc = 0;
                gap = (ap >= NDIR) && (($urandom % 5) == 0);
                gk  = $urandom % 3;
            end
        end

        // Reset asserted in the middle of an ACCESS to slave 2
        @(posedge H_CLK);
        #1;
        H_SEL = 1'b1; H_TRANS = 2'b10; H_WRITE = 1'b0; H_SIZE = 3'd2;
        H_ADDR = 32'h0000_2010; H_READY_IN = 1'b1; P_READY = '0; P_SLVERR = '0;
        @(posedge H_CLK);
        #1;
        H_SEL = 1'b0; H_TRANS = 2'b00;
        for (int i = 0; i < 10 && !P_ENABLE; i++) begin
            @(posedge H_CLK);
            #1;
        end
        chk("mid_access", {P_SEL, P_ENABLE}, {3'b100, 1'b1});
        #2;
        H_RESET_n = 1'b0;
        #1;
        chk("arst_psel", P_SEL, 3'b000);
        chk("arst_penable", P_ENABLE, 1'b0);
        chk("arst_hready", H_READY_OUT, 1'b1);
        chk("arst_hresp", H_RESP, 1'b0);
        chk("arst_paddr", P_ADDR, 32'h0);
        @(posedge H_CLK);
        #1;
        H_RESET_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
